// File: rtl/mcdf_reg_pkg.sv
// mcdf_reg_pkg: command codes, bus widths and FSM states shared by the MCDF register path
package mcdf_reg_pkg;
  localparam int CMD_ADDR_W = 6;
  localparam int CMD_DATA_W = 32;
  localparam int IDX_SHIFT = 4;
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [1:0] CMD_RD = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/mcdf_reg_cmd_master_if.sv
// mcdf_reg_cmd_master_if: host request/response channels plus the register command bus
interface mcdf_reg_cmd_master_if;
  import mcdf_reg_pkg::*;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [CMD_ADDR_W-1:0] req_addr_i;
  logic [CMD_DATA_W-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_write_o;
  logic [CMD_DATA_W-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic [1:0]            cmd_o;
  logic [CMD_ADDR_W-1:0] cmd_addr_o;
  logic [CMD_DATA_W-1:0] cmd_data_o;
  logic [CMD_DATA_W-1:0] cmd_rdata_i;
  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i, cmd_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_err_o, cmd_o, cmd_addr_o, cmd_data_o
  );
  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i, cmd_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_err_o, cmd_o, cmd_addr_o, cmd_data_o
  );
endinterface

// File: rtl/mcdf_reg_cmd_master.sv
// mcdf_reg_cmd_master: turns host requests into single WR/RD commands and returns responses
// MCDF_ADDR_CHECK_EN: answer misaligned or out-of-range addresses with an error, no command
module mcdf_reg_cmd_master
  import mcdf_reg_pkg::*;
#(
  parameter int RD_LAT        = 1,
  parameter int LEGAL_IDX_MAX = 2
) (
  input logic clk_i,
  input logic rst_i,
  mcdf_reg_cmd_master_if.master bus
);
  localparam bit CHK_EN =
`ifdef MCDF_ADDR_CHECK_EN
    1'b1;
`else
    1'b0;
`endif
  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [CMD_ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [CMD_DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [CMD_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CMD_ADDR_W-1:0] idx;
  logic                  illegal;
  assign idx = bus.req_addr_i >> IDX_SHIFT;
  assign illegal = CHK_EN && ((bus.req_addr_i[3:0] != 4'd0) || (int'(idx) > LEGAL_IDX_MAX));
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    cmd_d       = CMD_IDLE;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: if (bus.req_valid_i) begin
        wr_d = bus.req_write_i;
        if (illegal) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = bus.req_write_i;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          state_d    = S_ISSUE;
          cmd_d      = bus.req_write_i ? CMD_WR : CMD_RD;
          cmd_addr_d = bus.req_addr_i;
          cmd_data_d = bus.req_write_i ? bus.req_wdata_i : '0;
        end
      end
      S_ISSUE: if (wr_q) begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end else begin
        state_d = S_WAIT;
        cnt_d   = 3'(RD_LAT);
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = bus.cmd_rdata_i;
          rsp_err_d   = 1'b0;
        end
      end
      S_RESP: if (bus.rsp_ready_i) begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      cmd_q       <= CMD_IDLE;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      cmd_q       <= cmd_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
  assign bus.req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_write_o = rsp_write_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.cmd_o       = cmd_q;
  assign bus.cmd_addr_o  = cmd_addr_q;
  assign bus.cmd_data_o  = cmd_data_q;
endmodule
